// File: rtl/niu_sum_sequencer_pkg.sv
// Shared types and constants for the digit-sum control sequencer.
package niu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    STORE,
    DONE
  } seq_state_t;

  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_RESULT = 5'd31;

endpackage

// File: rtl/niu_sum_sequencer_if.sv
// Digit stream plus RegFile/ALU/Mux2/DataMemory control bus driven by the sequencer.
interface niu_sum_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic [3:0]            digit_in;
  logic                  digit_valid;
  logic                  digit_ready;
  logic                  RegWrite;
  logic                  ALUSrc;
  logic [3:0]            ALUCtl;
  logic [4:0]            ReadReg1;
  logic [4:0]            ReadReg2;
  logic [4:0]            WriteReg;
  logic [DATA_WIDTH-1:0] Immediate;
  logic                  MemWrite;
  logic                  MemRead;
  logic [ADDR_WIDTH-1:0] address;

  modport master (
    input  digit_in, digit_valid,
    output digit_ready, RegWrite, ALUSrc, ALUCtl, ReadReg1, ReadReg2, WriteReg,
           Immediate, MemWrite, MemRead, address
  );

  modport slave (
    output digit_in, digit_valid,
    input  digit_ready, RegWrite, ALUSrc, ALUCtl, ReadReg1, ReadReg2, WriteReg,
           Immediate, MemWrite, MemRead, address
  );
endinterface

// File: rtl/niu_sum_sequencer_buffer.sv
// Digit slot buffer: fills slot[count] on each accepted digit, cleared at end of run.
module niu_digit_buffer #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       idle,
  input  logic [3:0]                 digit_in,
  input  logic                       digit_valid,
  output logic                       digit_ready,
  output logic                       full,
  output logic [NUM_DIGITS-1:0][3:0] slots
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] CAP = CW'(NUM_DIGITS);

  logic [CW-1:0] count;

  assign full        = (count == CAP);
  assign digit_ready = idle && (count < CAP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      slots <= '0;
    end else if (clear) begin
      count <= '0;
      slots <= '0;
    end else if (digit_valid && digit_ready) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (count == CW'(i)) slots[i] <= digit_in;
      end
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/niu_sum_sequencer.sv
// Sequencer: loads buffered digits into $1..$N, chains ADDs into $31, stores $31 to memory.
module niu_sum_sequencer
  import niu_seq_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] store_addr,
  output logic                  busy,
  output logic                  done,
  niu_sum_sequencer_if.master   bus
);
  localparam logic [4:0] LAST_STEP = 5'(NUM_DIGITS - 1);
  localparam logic [4:0] N5        = 5'(NUM_DIGITS);

  seq_state_t                 state, state_nxt;
  logic [4:0]                 step, step_nxt;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [NUM_DIGITS-1:0][3:0] slots;
  logic                       count_full;
  logic                       start_ok;
  logic [3:0]                 imm_digit;

  niu_digit_buffer #(.NUM_DIGITS(NUM_DIGITS)) u_buf (
    .clock       (clock),
    .reset       (reset),
    .clear       (state == DONE),
    .idle        (state == IDLE),
    .digit_in    (bus.digit_in),
    .digit_valid (bus.digit_valid),
    .digit_ready (bus.digit_ready),
    .full        (count_full),
    .slots       (slots)
  );

  assign start_ok = start && (state == IDLE) && count_full;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE:  if (start_ok) begin state_nxt = LOAD; step_nxt = '0; end
      LOAD:  if (step == LAST_STEP) begin state_nxt = ADD; step_nxt = 5'd1; end
             else step_nxt = step + 5'd1;
      ADD:   if (step == LAST_STEP) begin state_nxt = STORE; step_nxt = '0; end
             else step_nxt = step + 5'd1;
      STORE: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imm_digit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (step_nxt == 5'(i)) imm_digit = slots[i];
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      step          <= '0;
      addr_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.RegWrite  <= 1'b0;
      bus.ALUSrc    <= 1'b0;
      bus.ALUCtl    <= '0;
      bus.ReadReg1  <= REG_ZERO;
      bus.ReadReg2  <= REG_ZERO;
      bus.WriteReg  <= REG_ZERO;
      bus.Immediate <= '0;
      bus.MemWrite  <= 1'b0;
      bus.MemRead   <= 1'b0;
      bus.address   <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      if (start_ok) addr_q <= store_addr;
      busy          <= (state_nxt == LOAD) || (state_nxt == ADD) || (state_nxt == STORE);
      done          <= (state_nxt == DONE);
      bus.RegWrite  <= 1'b0;
      bus.ALUSrc    <= 1'b0;
      bus.ALUCtl    <= '0;
      bus.ReadReg1  <= REG_ZERO;
      bus.ReadReg2  <= REG_ZERO;
      bus.WriteReg  <= REG_ZERO;
      bus.Immediate <= '0;
      bus.MemWrite  <= 1'b0;
      bus.MemRead   <= 1'b0;
      bus.address   <= '0;
      case (state_nxt)
        LOAD: begin
          bus.ALUCtl    <= ALU_ADD;
          bus.RegWrite  <= 1'b1;
          bus.ALUSrc    <= 1'b1;
          bus.WriteReg  <= step_nxt + 5'd1;
          bus.Immediate <= DATA_WIDTH'(imm_digit);
        end
        ADD: begin
          bus.ALUCtl   <= ALU_ADD;
          bus.RegWrite <= 1'b1;
          bus.ReadReg1 <= (step_nxt == 5'd1) ? 5'd1 : N5 + step_nxt - 5'd1;
          bus.ReadReg2 <= step_nxt + 5'd1;
          bus.WriteReg <= (step_nxt == LAST_STEP) ? REG_RESULT : N5 + step_nxt;
        end
        STORE: begin
          bus.ALUCtl   <= ALU_ADD;
          bus.ALUSrc   <= 1'b1;
          bus.ReadReg1 <= REG_RESULT;
          bus.MemWrite <= 1'b1;
          bus.address  <= addr_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_niu_sum_sequencer.sv
// Bench: sequencer driving a behavioural RegFile/ALU/DataMemory, checked against digit sums.
module tb_niu_sum_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start6 = 1'b0, start2 = 1'b0;
  logic busy6, busy2, done6, done2;
  logic [6:0] addr6 = '0, addr2 = '0;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  niu_sum_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus6 ();
  niu_sum_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus2 ();

  niu_sum_sequencer #(.NUM_DIGITS(6), .DATA_WIDTH(32), .ADDR_WIDTH(7)) dut6 (
    .clock(clock), .reset(reset), .start(start6), .store_addr(addr6),
    .busy(busy6), .done(done6), .bus(bus6)
  );

  niu_sum_sequencer #(.NUM_DIGITS(2), .DATA_WIDTH(32), .ADDR_WIDTH(7)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .store_addr(addr2),
    .busy(busy2), .done(done2), .bus(bus2)
  );

  // Behavioural datapath: ALU adds RegFile[ReadReg1] to the Mux2 output.
  logic [31:0] rf6 [32] = '{default: '0};
  logic [31:0] mem6 [128] = '{default: 32'hDEADBEEF};
  logic [31:0] rf2 [32] = '{default: '0};
  logic [31:0] mem2 [128] = '{default: 32'hDEADBEEF};
  logic [31:0] alu6, alu2;

  assign alu6 = rf6[bus6.ReadReg1] + (bus6.ALUSrc ? bus6.Immediate : rf6[bus6.ReadReg2]);
  assign alu2 = rf2[bus2.ReadReg1] + (bus2.ALUSrc ? bus2.Immediate : rf2[bus2.ReadReg2]);

  always @(posedge clock) begin
    if (bus6.RegWrite && bus6.WriteReg != 5'd0) rf6[bus6.WriteReg] <= alu6;
    if (bus6.MemWrite) mem6[bus6.address] <= alu6;
    if (bus2.RegWrite && bus2.WriteReg != 5'd0) rf2[bus2.WriteReg] <= alu2;
    if (bus2.MemWrite) mem2[bus2.address] <= alu2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed6(input logic [3:0] d);
    @(negedge clock);
    bus6.digit_in    = d;
    bus6.digit_valid = 1'b1;
    @(negedge clock);
    bus6.digit_valid = 1'b0;
  endtask

  task automatic run6(input logic [5:0][3:0] d, input logic [6:0] a, input int first,
                      input string tag);
    int c, busy_cnt, alu_bad, mw_cycle;
    logic [6:0] mw_addr;
    int unsigned sum;
    for (int i = first; i < 6; i++) feed6(d[i]);
    check({tag, ":ready_full"}, 32'(bus6.digit_ready), 32'd0);
    feed6(4'd15);
    @(negedge clock);
    start6 = 1'b1;
    addr6  = a;
    @(negedge clock);
    start6 = 1'b0;
    addr6  = ~a;
    bus6.digit_in    = 4'd15;
    bus6.digit_valid = 1'b1;
    c = 0; busy_cnt = 0; alu_bad = 0; mw_cycle = -1; mw_addr = '0;
    while (!done6 && c < 40) begin
      if (busy6) busy_cnt++;
      if (busy6 && bus6.ALUCtl !== 4'b0010) alu_bad++;
      if (bus6.MemWrite) begin mw_cycle = c; mw_addr = bus6.address; end
      @(negedge clock);
      c++;
    end
    bus6.digit_valid = 1'b0;
    check({tag, ":done_latency"}, 32'(c), 32'd12);
    check({tag, ":busy_cycles"}, 32'(busy_cnt), 32'd12);
    check({tag, ":aluctl_bad"}, 32'(alu_bad), 32'd0);
    check({tag, ":store_cycle"}, 32'(mw_cycle), 32'd11);
    check({tag, ":store_addr"}, 32'(mw_addr), 32'(a));
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      sum += 32'(d[i]);
      check({tag, ":load_reg"}, rf6[i+1], 32'(d[i]));
      if (i >= 1 && i <= 4) check({tag, ":partial_reg"}, rf6[6+i], sum);
    end
    check({tag, ":reg31"}, rf6[31], sum);
    check({tag, ":mem"}, mem6[a], sum);
    @(negedge clock);
    check({tag, ":done_pulse"}, 32'(done6), 32'd0);
    check({tag, ":ready_after"}, 32'(bus6.digit_ready), 32'd1);
  endtask

  initial begin
    logic [5:0][3:0] dv;
    int c, mw_cycle, bad;
    bus6.digit_in = '0; bus6.digit_valid = 1'b0;
    bus2.digit_in = '0; bus2.digit_valid = 1'b0;

    #1;
    check("rst:ready", 32'(bus6.digit_ready), 32'd1);
    check("rst:busy", 32'(busy6), 32'd0);
    check("rst:done", 32'(done6), 32'd0);
    check("rst:regwrite", 32'(bus6.RegWrite), 32'd0);
    check("rst:memwrite", 32'(bus6.MemWrite), 32'd0);
    check("rst:aluctl", 32'(bus6.ALUCtl), 32'd0);
    check("rst:writereg", 32'(bus6.WriteReg), 32'd0);
    check("rst:immediate", bus6.Immediate, 32'd0);
    check("rst:address", 32'(bus6.address), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed run: 5,2,0,5,6,3 -> 21 at address 0
    dv = {4'd3, 4'd6, 4'd5, 4'd0, 4'd2, 4'd5};
    run6(dv, 7'd0, 0, "basic");

    // Start with only four digits is ignored
    for (int i = 0; i < 6; i++) dv[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) feed6(dv[i]);
    @(negedge clock); start6 = 1'b1;
    @(negedge clock); start6 = 1'b0;
    bad = 0;
    repeat (3) begin
      if (busy6 || bus6.RegWrite || !bus6.digit_ready) bad++;
      @(negedge clock);
    end
    check("partial:start_ignored", 32'(bad), 32'd0);
    run6(dv, 7'd50, 4, "partial");

    // Sixth digit and start on the same edge: digit taken, start ignored
    for (int i = 0; i < 6; i++) dv[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 5; i++) feed6(dv[i]);
    @(negedge clock);
    bus6.digit_in = dv[5]; bus6.digit_valid = 1'b1; start6 = 1'b1;
    @(negedge clock);
    bus6.digit_valid = 1'b0; start6 = 1'b0;
    check("same_edge:busy", 32'(busy6), 32'd0);
    check("same_edge:ready", 32'(bus6.digit_ready), 32'd0);
    run6(dv, 7'd60, 6, "same_edge");

    // Reset during the third ADD cycle
    for (int i = 0; i < 6; i++) dv[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 6; i++) feed6(dv[i]);
    @(negedge clock); start6 = 1'b1; addr6 = 7'd0;
    @(negedge clock); start6 = 1'b0;
    repeat (8) @(negedge clock);
    check("abort:pre_regwrite", 32'(bus6.RegWrite), 32'd1);
    check("abort:pre_writereg", 32'(bus6.WriteReg), 32'd9);
    #2 reset = 1'b1;
    #1;
    check("abort:regwrite", 32'(bus6.RegWrite), 32'd0);
    check("abort:memwrite", 32'(bus6.MemWrite), 32'd0);
    check("abort:busy", 32'(busy6), 32'd0);
    check("abort:ready", 32'(bus6.digit_ready), 32'd1);
    @(negedge clock); reset = 1'b0;
    repeat (14) @(negedge clock);
    check("abort:mem0", mem6[0], 32'd21);
    check("abort:idle_busy", 32'(busy6), 32'd0);

    // Nines at 127, then 1,0,0,0,0,0 at 1
    dv = {4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    run6(dv, 7'd127, 0, "nines");
    dv = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    run6(dv, 7'd1, 0, "one");
    check("one:mem127_kept", mem6[127], 32'd54);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) dv[i] = 4'($urandom_range(0, 15));
      run6(dv, 7'($urandom_range(2, 126)), 0, "rand");
    end

    // Two-digit instance: 15 + 15
    @(negedge clock); bus2.digit_in = 4'd15; bus2.digit_valid = 1'b1;
    @(negedge clock);
    @(negedge clock); bus2.digit_valid = 1'b0;
    check("n2:ready_full", 32'(bus2.digit_ready), 32'd0);
    @(negedge clock); start2 = 1'b1; addr2 = 7'd42;
    @(negedge clock); start2 = 1'b0;
    c = 0; mw_cycle = -1;
    while (!done2 && c < 40) begin
      if (bus2.MemWrite) mw_cycle = c;
      @(negedge clock);
      c++;
    end
    check("n2:done_latency", 32'(c), 32'd4);
    check("n2:store_cycle", 32'(mw_cycle), 32'd3);
    check("n2:reg1", rf2[1], 32'd15);
    check("n2:reg2", rf2[2], 32'd15);
    check("n2:reg31", rf2[31], 32'd30);
    check("n2:mem", mem2[42], 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
